// File: rtl/regfile_dump_streamer_pkg.sv
// regfile_dump_streamer_pkg: shared state encoding and helpers for the register-file dump streamer.
//   dump_state_t : 2-bit FSM state (IDLE=0, READ=1, SEND=2, DONE=3)
//   first_index  : starting register index of a walk, depending on whether $0 is skipped
package regfile_dump_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

    function automatic int first_index(input bit skip_zero);
        return skip_zero ? 1 : 0;
    endfunction

endpackage

// File: rtl/regfile_dump_streamer.sv
// regfile_dump_streamer: halts the CPU and streams every register as an {index, value} beat.
//   i_clk        rising-edge clock, shared with the cpu
//   i_reset      asynchronous active-high reset
//   i_start      single-cycle request to begin a dump (honoured only in IDLE)
//   o_cpu_halt   high for the whole dump; cpu freezes PC and regfile writes
//   o_rd_addr    spare regfile read address
//   i_rd_data    combinational read data for o_rd_addr
//   o_out_valid  beat available
//   i_out_ready  consumer accepts beat
//   o_out_index  register index of current beat
//   o_out_data   register value of current beat
//   o_busy       high in any non-IDLE state
//   o_done       one-cycle pulse after the last beat is accepted
module regfile_dump_streamer
    import regfile_dump_streamer_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int SKIP_ZERO = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_cpu_halt,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_index,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(first_index(SKIP_ZERO != 0));
    // Walk ends on an exact compare, so idx never needs to wrap past the last register.
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    dump_state_t       r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_valid;
    logic              r_done;
    logic              r_busy;
    logic [ADDR_W-1:0] r_index;
    logic [DATA_W-1:0] r_data;
    logic              w_accept;

    assign w_accept    = r_valid & i_out_ready;
    assign o_rd_addr   = r_idx;
    assign o_out_valid = r_valid;
    assign o_out_index = r_index;
    assign o_out_data  = r_data;
    assign o_done      = r_done;
    assign o_busy      = r_busy;
    // Halt is exactly the busy window: it covers READ, SEND and DONE.
    assign o_cpu_halt  = r_busy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_index <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_idx   <= FIRST_IDX;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_data  <= i_rd_data;
                    r_index <= r_idx;
                    r_valid <= 1'b1;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_accept) begin
                        r_valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// tb_regfile_dump_streamer: table-driven and randomized checks of the dump streamer against a queue model.
module tb_regfile_dump_streamer;

    localparam int NR = 32;

    typedef struct {
        int mul;
        int add;
        int pct;
        int stall_at;
        int dut;
        int exp_first;
        int exp_beats;
        bit cpu;
        bit poke;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [2];
    logic        ready [2];
    logic        halt  [2];
    logic        valid [2];
    logic        busy  [2];
    logic        done  [2];
    logic [4:0]  rd_addr [2];
    logic [4:0]  oidx    [2];
    logic [31:0] rd_data [2];
    logic [31:0] odata   [2];

    logic [31:0] regs [NR];
    logic        ld_go  = 1'b0;
    logic [31:0] ld_mul = '0;
    logic [31:0] ld_add = '0;
    logic        cpu_en = 1'b0;
    int          pc     = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rd_data[0] = regs[rd_addr[0]];
    assign rd_data[1] = regs[rd_addr[1]];

    // Regfile owner: bench preloads, or a toy cpu that writes one register per unhalted cycle.
    always @(posedge clk) begin
        if (ld_go) begin
            for (int k = 0; k < NR; k++) regs[k] <= 32'(k) * ld_mul + ld_add;
        end else if (cpu_en && !halt[0]) begin
            regs[pc[4:0]] <= 32'(pc) * 7 + 1;
            pc <= pc + 1;
        end
    end

    regfile_dump_streamer #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_ZERO(0)) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start[0]), .o_cpu_halt(halt[0]),
        .o_rd_addr(rd_addr[0]), .i_rd_data(rd_data[0]), .o_out_valid(valid[0]),
        .i_out_ready(ready[0]), .o_out_index(oidx[0]), .o_out_data(odata[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );

    regfile_dump_streamer #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start[1]), .o_cpu_halt(halt[1]),
        .o_rd_addr(rd_addr[1]), .i_rd_data(rd_data[1]), .o_out_valid(valid[1]),
        .i_out_ready(ready[1]), .o_out_index(oidx[1]), .o_out_data(odata[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [31:0] m, input logic [31:0] a);
        ld_mul = m;
        ld_add = a;
        ld_go  = 1'b1;
        step();
        ld_go  = 1'b0;
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        chk({tag, "_halt"}, 64'(halt[d]), 0);
        chk({tag, "_valid"}, 64'(valid[d]), 0);
        chk({tag, "_busy"}, 64'(busy[d]), 0);
        chk({tag, "_done"}, 64'(done[d]), 0);
        chk({tag, "_index"}, 64'(oidx[d]), 0);
        chk({tag, "_data"}, 64'(odata[d]), 0);
        chk({tag, "_rdaddr"}, 64'(rd_addr[d]), 0);
    endtask

    task automatic run_dump(input vec_t v);
        int          d = v.dut;
        int          exp_idx [$];
        logic [31:0] exp_dat [$];
        int          n;
        int          busy_cnt = 0;
        int          done_cnt = 0;
        int          done_at  = 0;
        int          stalls   = 0;
        int          held     = 0;
        int          beats    = 0;
        int          first_seen = -1;
        int          pc_snap;
        bit          timeout  = 1'b1;
        logic [4:0]  h_idx = '0;
        logic [31:0] h_dat = '0;
        if (v.cpu) begin
            cpu_en = 1'b1;
            repeat (3) step();
        end else begin
            preload(32'(v.mul), v.add < 0 ? $urandom : 32'(v.add));
        end
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
        // Halt is up now, so the regfile is frozen: this is the image the stream must reproduce.
        pc_snap = pc;
        for (int k = (d == 1 ? 1 : 0); k < NR; k++) begin
            exp_idx.push_back(k);
            exp_dat.push_back(regs[k]);
        end
        n = exp_idx.size();
        chk("busy_rise", 64'(busy[d]), 1);
        chk("halt_rise", 64'(halt[d]), 1);
        chk("no_valid_first_cycle", 64'(valid[d]), 0);
        for (int c = 0; c < 800; c++) begin
            if (!busy[d]) begin
                timeout = 1'b0;
                break;
            end
            busy_cnt++;
            chk("halt_eq_busy", 64'(halt[d]), 1);
            if (done[d]) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (valid[d] && held > 0) begin
                chk("hold_index", 64'(oidx[d]), 64'(h_idx));
                chk("hold_data", 64'(odata[d]), 64'(h_dat));
            end
            if (v.poke) start[d] = valid[d] | done[d];
            if (valid[d] && exp_idx.size() > 0 && exp_idx[0] == v.stall_at && held < 5)
                ready[d] = 1'b0;
            else
                ready[d] = ($urandom_range(99) < 32'(v.pct));
            if (valid[d] && ready[d]) begin
                if (exp_idx.size() == 0) begin
                    chk("extra_beat", 64'(oidx[d]), 64'hffff);
                end else begin
                    chk("beat_index", 64'(oidx[d]), 64'(exp_idx[0]));
                    chk("beat_data", 64'(odata[d]), 64'(exp_dat[0]));
                    if (first_seen < 0) first_seen = exp_idx[0];
                    void'(exp_idx.pop_front());
                    void'(exp_dat.pop_front());
                    beats++;
                end
                held = 0;
            end else if (valid[d]) begin
                held++;
                stalls++;
                h_idx = oidx[d];
                h_dat = odata[d];
            end
            step();
        end
        start[d] = 1'b0;
        ready[d] = 1'b0;
        chk("timeout", 64'(timeout), 0);
        chk("beat_count", 64'(beats), 64'(v.exp_beats));
        chk("first_index", 64'(first_seen), 64'(v.exp_first));
        chk("done_pulses", 64'(done_cnt), 1);
        chk("done_cycle", 64'(done_at), 64'(2 * n + 1 + stalls));
        chk("busy_cycles", 64'(busy_cnt), 64'(2 * n + 1 + stalls));
        chk("halt_fall", 64'(halt[d]), 0);
        if (v.cpu) begin
            chk("pc_frozen", 64'(pc), 64'(pc_snap));
            repeat (3) step();
            chk("pc_resumed", 64'(pc), 64'(pc_snap + 3));
            cpu_en = 1'b0;
        end
        if (v.poke) begin
            repeat (4) begin
                step();
                chk("ignored_start_busy", 64'(busy[d]), 0);
                chk("ignored_start_done", 64'(done[d]), 0);
            end
        end
    endtask

    vec_t tbl [7];

    initial begin
        bit found;
        start[0] = 1'b0;
        start[1] = 1'b0;
        ready[0] = 1'b0;
        ready[1] = 1'b0;
        tbl[0] = '{mul: 3, add: 0,  pct: 100, stall_at: -1, dut: 0, exp_first: 0, exp_beats: 32, cpu: 0, poke: 0};
        tbl[1] = '{mul: 3, add: 0,  pct: 100, stall_at: 7,  dut: 0, exp_first: 0, exp_beats: 32, cpu: 0, poke: 0};
        tbl[2] = '{mul: 5, add: -1, pct: 50,  stall_at: -1, dut: 0, exp_first: 0, exp_beats: 32, cpu: 0, poke: 0};
        tbl[3] = '{mul: 3, add: 0,  pct: 100, stall_at: -1, dut: 1, exp_first: 1, exp_beats: 31, cpu: 0, poke: 0};
        tbl[4] = '{mul: 9, add: -1, pct: 40,  stall_at: -1, dut: 1, exp_first: 1, exp_beats: 31, cpu: 0, poke: 0};
        tbl[5] = '{mul: 11, add: 2, pct: 60,  stall_at: -1, dut: 0, exp_first: 0, exp_beats: 32, cpu: 0, poke: 1};
        tbl[6] = '{mul: 0, add: 0,  pct: 75,  stall_at: -1, dut: 0, exp_first: 0, exp_beats: 32, cpu: 1, poke: 0};

        #2;
        check_idle_outputs(0, "rst0");
        check_idle_outputs(1, "rst1");
        start[0] = 1'b1;
        step();
        chk("start_under_reset", 64'(busy[0]), 0);
        start[0] = 1'b0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_dump(tbl[i]);

        preload(32'd4, 32'd1);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        ready[0] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (valid[0] && oidx[0] == 5'd10) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("reach_beat10", 64'(found), 1);
        chk("beat10_data", 64'(odata[0]), 64'd41);
        rst = 1'b1;
        #1;
        check_idle_outputs(0, "async_rst");
        ready[0] = 1'b0;
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            chk("post_rst_busy", 64'(busy[0]), 0);
            chk("post_rst_done", 64'(done[0]), 0);
        end
        run_dump('{mul: 2, add: 1, pct: 80, stall_at: -1, dut: 0, exp_first: 0, exp_beats: 32, cpu: 0, poke: 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
